// File: rtl/timer_scheduler.sv
// Shared delay counter handed out to N_REQ requesters; one job at a time, done pulse per owner.
// Optional build macro SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module timer_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] delay,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;

  logic [IDX_W-1:0]   scan_start;
  logic [IDX_W-1:0]   win;
  logic [N_REQ-1:0]   win_onehot;
  logic [CNT_W-1:0]   win_delay;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   rot_off;
  logic [IDX_W:0]     win_sum;

  // Rotate req so the pointer position lands on bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> scan_start;
    req_rot = req_dbl[N_REQ-1:0];
    rot_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rot_off = IDX_W'(k);
      end
    end
    win_sum = {1'b0, scan_start} + {1'b0, rot_off};
    if (win_sum >= (IDX_W + 1)'(N_REQ)) begin
      win_sum = win_sum - (IDX_W + 1)'(N_REQ);
    end
    win = win_sum[IDX_W-1:0];
  end

  always_comb begin
    win_onehot = '0;
    win_delay  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_delay     = delay[i*CNT_W +: CNT_W];
      end
    end
  end

`ifdef SCHED_FIXED_PRIO_EN
  assign scan_start = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && req != '0) begin
      ptr_d = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign scan_start = ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = RUN;
          grant_d = win_onehot;
          dly_d   = win_delay;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // A dropped request aborts silently and wins over a same-cycle completion.
        if ((req & grant_q) == '0) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == dly_q) begin
          state_d = DONE;
          grant_d = '0;
          done_d  = grant_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign cnt_out = cnt_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: expected grant/done/abort events are queued by the stimulus
// and matched, with their cycle numbers, by an independent monitor.
module tb_timer_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 9;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] delay;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [CNT_W-1:0]       cnt_out;

  typedef struct {
    string      name;
    int         kind;
    logic [3:0] val;
    int         cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [N_REQ-1:0] prev_grant = '0;

  timer_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .delay   (delay),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .cnt_out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input string nm, input int kind, input logic [3:0] v, input int c);
    ev_t e;
    e.name = nm;
    e.kind = kind;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [3:0] v);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value %b at cycle %0d, expected no event", kind, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != v || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got kind %0d value %b cycle %0d, expected kind %0d value %b cycle %0d",
                 e.name, kind, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: turns output activity into events and checks invariants every cycle.
  always @(negedge clk) begin
    chk("grant_onehot0", int'($onehot0(grant)), 1);
    chk("done_onehot0", int'($onehot0(done)), 1);
    chk("grant_done_disjoint", int'((grant & done) == '0), 1);
    if (done != '0) got(EV_DONE, done);
    if (grant != '0 && grant != prev_grant) got(EV_GRANT, grant);
    if (prev_grant != '0 && grant == '0 && done == '0) got(EV_ABORT, 4'b0000);
    prev_grant <= grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before time 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int c2;
    logic [3:0] gv;
    logic [3:0] sv;

    rst_n = 1'b1;
    req   = '0;
    delay = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(cnt_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: single requester, delay 5.
    @(negedge clk);
    c = cyc;
    delay[0*CNT_W +: CNT_W] = 9'd5;
    req = 4'b0001;
    expect_ev("t1_grant", EV_GRANT, 4'b0001, c + 1);
    expect_ev("t1_done", EV_DONE, 4'b0001, c + 7);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t1_cnt_ramp", int'(cnt_out), k);
      chk("t1_busy_run", int'(busy), 1);
    end
    @(negedge clk);
    chk("t1_cnt_in_done", int'(cnt_out), 0);
    chk("t1_busy_in_done", int'(busy), 1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_busy_after", int'(busy), 0);

    // Test 2/3: all requesters held with delay 2.
    do_reset();
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < N_REQ; i++) delay[i*CNT_W +: CNT_W] = 9'd2;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef SCHED_FIXED_PRIO_EN
      gv = 4'b0001;
`else
      sv = 4'b0001;
      gv = sv << (k % 4);
`endif
      expect_ev("t2_grant", EV_GRANT, gv, c + 1 + 5 * k);
      expect_ev("t2_done", EV_DONE, gv, c + 4 + 5 * k);
    end
    repeat (24) @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Test 4: abort of a long job, pending req2 served next; late delay change ignored.
    do_reset();
    @(negedge clk);
    c = cyc;
    delay[0*CNT_W +: CNT_W] = 9'd100;
    delay[2*CNT_W +: CNT_W] = 9'd3;
    req = 4'b0101;
    expect_ev("t4_grant0", EV_GRANT, 4'b0001, c + 1);
    expect_ev("t4_abort", EV_ABORT, 4'b0000, c + 42);
    expect_ev("t4_grant2", EV_GRANT, 4'b0100, c + 43);
    expect_ev("t4_done2", EV_DONE, 4'b0100, c + 47);
    repeat (41) @(negedge clk);
    chk("t4_cnt_at_drop", int'(cnt_out), 40);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_busy_abort", int'(busy), 0);
    chk("t4_cnt_abort", int'(cnt_out), 0);
    @(negedge clk);
    delay[2*CNT_W +: CNT_W] = 9'd50;
    repeat (4) @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Test 5: maximum delay, no wrap.
    c = cyc;
    delay[1*CNT_W +: CNT_W] = 9'd511;
    req = 4'b0010;
    expect_ev("t5_grant", EV_GRANT, 4'b0010, c + 1);
    expect_ev("t5_done", EV_DONE, 4'b0010, c + 513);
    repeat (512) @(negedge clk);
    chk("t5_cnt_max", int'(cnt_out), 511);
    chk("t5_grant_held", int'(grant), 2);
    @(negedge clk);
    chk("t5_cnt_after", int'(cnt_out), 0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Test 6: asynchronous reset mid-run restores pointer to 0.
    c = cyc;
    delay[1*CNT_W +: CNT_W] = 9'd10;
    req = 4'b0010;
    expect_ev("t6_grant", EV_GRANT, 4'b0010, c + 1);
    repeat (4) @(negedge clk);
    chk("t6_cnt_before_rst", int'(cnt_out), 3);
    #2;
    expect_ev("t6_rst_abort", EV_ABORT, 4'b0000, c + 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", int'(grant), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_cnt", int'(cnt_out), 0);
    chk("t6_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    delay[1*CNT_W +: CNT_W] = 9'd1;
    delay[3*CNT_W +: CNT_W] = 9'd1;
    c2 = cyc;
`ifdef SCHED_FIXED_PRIO_EN
    gv = 4'b0010;
`else
    gv = 4'b1000;
`endif
    expect_ev("t6_grant_a", EV_GRANT, 4'b0010, c2 + 1);
    expect_ev("t6_done_a", EV_DONE, 4'b0010, c2 + 3);
    expect_ev("t6_grant_b", EV_GRANT, gv, c2 + 5);
    expect_ev("t6_done_b", EV_DONE, gv, c2 + 7);
    repeat (7) @(negedge clk);
    req = 4'b0000;
    repeat (10) @(negedge clk);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no event, expected kind %0d value %b at cycle %0d", e.name, e.kind, e.val, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
